// File: rtl/matmul_sequencer.sv
// Instruction sequencer for the systolic MAC array: pops one decoded instruction,
// streams its V/U/ITER unified-buffer reads, and mirrors them as delayed writes.
package matmul_sequencer_pkg;
  localparam int UB_ADDR_W   = 12;
  localparam int DIM_FIELD_W = 8;

  localparam logic [2:0] MAC_OP_MATMUL = 3'b010;

  typedef struct packed {
    logic [2:0]             MAC_op;
    logic [DIM_FIELD_W-1:0] V_dim1;
    logic [DIM_FIELD_W-1:0] U_dim1;
    logic [DIM_FIELD_W-1:0] ITER_dim1;
    logic [DIM_FIELD_W-1:0] V_dim;
    logic [DIM_FIELD_W-1:0] U_dim;
    logic [DIM_FIELD_W-1:0] ITER_dim;
    logic [UB_ADDR_W-1:0]   unified_buffer_addr_start_rd;
    logic [UB_ADDR_W-1:0]   unified_buffer_addr_start_wr;
  } decode_registers_t;
endpackage

module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int ADDR_W   = UB_ADDR_W,
  parameter int DIM_W    = DIM_FIELD_W,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  decode_registers_t decoded_instruction_i,
  input  logic              ub_ready_i,
  output logic              instruction_read_o,
  output logic              ub_rd_en_o,
  output logic [ADDR_W-1:0] ub_rd_addr_o,
  output logic              ub_wr_en_o,
  output logic [ADDR_W-1:0] ub_wr_addr_o,
  output logic [2:0]        mac_op_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Delay-line pattern holding only the final outstanding write at the output tap.
  localparam logic [PIPE_LAT-1:0] LAST_WRITE_ONLY = PIPE_LAT'(1) << (PIPE_LAT - 1);

  state_t              state;
  logic [DIM_W-1:0]    v_dim1_q;
  logic [DIM_W-1:0]    u_dim1_q;
  logic [DIM_W-1:0]    it_dim1_q;
  logic [DIM_W-1:0]    v_cnt;
  logic [DIM_W-1:0]    u_cnt;
  logic [DIM_W-1:0]    it_cnt;
  logic [ADDR_W-1:0]   start_rd_q;
  logic [ADDR_W-1:0]   start_wr_q;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [PIPE_LAT-1:0] wr_pipe;

  logic is_noop;
  logic rd_fire;
  logic last_read;

  assign is_noop = (decoded_instruction_i.MAC_op != MAC_OP_MATMUL) ||
                   (decoded_instruction_i.V_dim == '0) ||
                   (decoded_instruction_i.U_dim == '0) ||
                   (decoded_instruction_i.ITER_dim == '0);

  assign rd_fire   = (state == RUN) && ub_ready_i;
  assign last_read = rd_fire && (v_cnt == v_dim1_q) && (u_cnt == u_dim1_q) &&
                     (it_cnt == it_dim1_q);

  // The pop strobe is qualified by valid so the queue is never popped while empty.
  assign instruction_read_o = (state == FETCH) && instr_valid_i;
  assign ub_rd_en_o         = rd_fire;
  assign ub_rd_addr_o       = start_rd_q + rd_ptr;
  assign ub_wr_en_o         = wr_pipe[PIPE_LAT-1];
  assign ub_wr_addr_o       = start_wr_q + wr_ptr;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mac_op_o   <= 3'b000;
      v_dim1_q   <= '0;
      u_dim1_q   <= '0;
      it_dim1_q  <= '0;
      v_cnt      <= '0;
      u_cnt      <= '0;
      it_cnt     <= '0;
      start_rd_q <= '0;
      start_wr_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wr_pipe    <= '0;
    end else begin
      wr_pipe <= PIPE_LAT'({wr_pipe, rd_fire});
      done_o  <= 1'b0;
      if (ub_wr_en_o) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (instr_valid_i) begin
            state  <= FETCH;
            busy_o <= 1'b1;
          end
        end

        FETCH: begin
          if (!instr_valid_i) begin
            // Head vanished before the pop: nothing was consumed, so just back off.
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            v_dim1_q   <= decoded_instruction_i.V_dim1;
            u_dim1_q   <= decoded_instruction_i.U_dim1;
            it_dim1_q  <= decoded_instruction_i.ITER_dim1;
            start_rd_q <= decoded_instruction_i.unified_buffer_addr_start_rd;
            start_wr_q <= decoded_instruction_i.unified_buffer_addr_start_wr;
            v_cnt      <= '0;
            u_cnt      <= '0;
            it_cnt     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            if (is_noop) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state    <= RUN;
              mac_op_o <= decoded_instruction_i.MAC_op;
            end
          end
        end

        RUN: begin
          if (rd_fire) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (v_cnt == v_dim1_q) begin
              v_cnt <= '0;
              if (u_cnt == u_dim1_q) begin
                u_cnt  <= '0;
                it_cnt <= it_cnt + DIM_W'(1);
              end else begin
                u_cnt <= u_cnt + DIM_W'(1);
              end
            end else begin
              v_cnt <= v_cnt + DIM_W'(1);
            end
            if (last_read) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // The final write is on the output tap this cycle; retire right after it.
          if (wr_pipe == LAST_WRITE_ONLY) begin
            state    <= DONE;
            done_o   <= 1'b1;
            mac_op_o <= 3'b000;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Consumes decoded instructions from the head of the instruction queue and executes each one as a timed stream of unified-buffer read and write enables/addresses for the systolic MAC array.
- Sits directly downstream of the instruction queue/decoder.
- Pops one instruction at a time, runs the nested V/U/ITER loop, drains the array pipeline, then fetches the next instruction.

Parameters:
- ADDR_W, 12, unified buffer address width.
- DIM_W, 8, width of V/U/ITER dimension fields.
- PIPE_LAT, 4, cycles from a UB read to its result being written back (must be ≥1).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- instr_valid_i  input  1  queue head holds a valid decoded instruction
- decoded_instruction_i  input  decode_registers_t  head instruction; fields used: MAC_op, V_dim1, U_dim1, ITER_dim1, V_dim, U_dim, ITER_dim, unified_buffer_addr_start_rd, unified_buffer_addr_start_wr
- ub_ready_i  input  1  UB accepts an access this cycle (stall when 0)
- instruction_read_o  output  1  one-cycle pop strobe to the queue
- ub_rd_en_o  output  1  UB read enable
- ub_rd_addr_o  output  ADDR_W  UB read address
- ub_wr_en_o  output  1  UB write enable
- ub_wr_addr_o  output  ADDR_W  UB write address
- mac_op_o  output  3  MAC opcode presented to the array while busy
- busy_o  output  1  instruction in progress
- done_o  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (sync, rst_i=1 at posedge):
  - All outputs 0, state=IDLE, all counters 0, PIPE_LAT delay line cleared.
  - Reset mid-RUN/DRAIN abandons the instruction: no done_o, no further UB accesses.
- States: IDLE, FETCH, RUN, DRAIN, DONE.
- IDLE:
  - busy_o=0.
  - If instr_valid_i=1, go to FETCH.
- FETCH (exactly 1 cycle):
  - instruction_read_o=1.
  - Latch all used fields from decoded_instruction_i.
  - Clear v_cnt, u_cnt, it_cnt, rd_ptr, wr_ptr.
  - busy_o=1 from here until DONE inclusive.
  - Next state: if MAC_op!=3'b010 or any of V_dim/U_dim/ITER_dim==0, go to DONE (no-op, zero UB accesses). Otherwise go to RUN.
- RUN:
  - ub_rd_en_o=ub_ready_i.
  - ub_rd_addr_o = start_rd + rd_ptr, modulo 2^ADDR_W (wraps).
  - Each accepted read (ub_rd_en_o=1):
    - rd_ptr++.
    - v_cnt increments fastest; when v_cnt==V_dim1 it clears and u_cnt++.
    - When u_cnt==U_dim1 (and v wraps) it clears and it_cnt++.
  - Total reads = V_dim*U_dim*ITER_dim.
  - ub_ready_i=0 freezes counters and address; no enable.
  - Read accepted with v_cnt==V_dim1, u_cnt==U_dim1, it_cnt==ITER_dim1: next state DRAIN.
  - mac_op_o = latched MAC_op in RUN and DRAIN, else 0.
- Write path:
  - ub_wr_en_o is ub_rd_en_o delayed exactly PIPE_LAT cycles through a shift register that is independent of ub_ready_i.
  - ub_wr_addr_o = start_wr + wr_ptr, modulo 2^ADDR_W.
  - wr_ptr increments after each asserted ub_wr_en_o.
  - Write count always equals read count.
- DRAIN:
  - No reads issued.
  - Leave when the delay line is empty and the final write has been issued, i.e. the last write occurs in the last DRAIN cycle.
  - Next state DONE.
- DONE (1 cycle):
  - done_o=1.
  - Next state IDLE; the next instruction can enter FETCH at the earliest on the following cycle.
- Latency for an instruction with N reads and no stalls:
  - FETCH at cycle t, reads t+1..t+N.
  - Last write at t+N+PIPE_LAT, done_o at t+N+PIPE_LAT+1.
- Boundaries:
  - instr_valid_i dropping during RUN has no effect.
  - instruction_read_o is never asserted outside FETCH and never when instr_valid_i=0.
  - Back-to-back instructions never overlap.
  - Dimension 255 with start address 0xFFF: address wraps to 0x000, 0x001, …

Test Plan:
- V=2, U=2, ITER=1, start_rd=0x010, start_wr=0x100, ub_ready=1, PIPE_LAT=4 -> one pop; reads 0x010..0x013 on 4 consecutive cycles; writes 0x100..0x103 exactly 4 cycles later; done_o 1 cycle after last write; busy_o high FETCH..DONE.
- Same instruction, ub_ready_i=0 for 2 cycles after the second read -> read addresses hold at 0x012 during the stall; total reads/writes still 4; done_o delayed 2 cycles.
- V=3, U=1, ITER=1, start_rd=0xFFE -> read addresses 0xFFE, 0xFFF, 0x000.
- MAC_op=3'b000 or U_dim=0 -> instruction_read_o pulse, no ub_rd_en_o/ub_wr_en_o, done_o 1 cycle after FETCH.
- Two valid instructions queued (V=U=ITER=1 each) -> two separate pops, each followed by 1 read, 1 write, done; second FETCH only after first DONE.
- rst_i asserted 2 cycles into RUN -> next cycle all outputs 0, state IDLE, no done_o, pending delayed writes suppressed.
